// File: rtl/grand_encoder.sv
// Systematic Hamming encoder ((8,4) extended or (7,4)) with channel-error injection,
// an output FIFO behind valid/ready handshakes, and word/injection statistics.
module grand_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_data,
  input  logic [0:WIDTH-1]         in_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [0:WIDTH-1]         out_cw,
  output logic [0:WIDTH-1]         out_clean,
  output logic                     out_flip,
  output logic [CNT_W-1:0]         word_cnt,
  output logic [CNT_W-1:0]         inj_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam bit          LEGAL = (WIDTH == 7) || (WIDTH == 8);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_nxt;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_inj_cnt;

  logic [0:WIDTH-1] r_mem_clean [DEPTH];
  logic [0:WIDTH-1] r_mem_cw    [DEPTH];
  logic [DEPTH-1:0] r_mem_flip;

  logic [0:WIDTH-1] r_out_cw;
  logic [0:WIDTH-1] r_out_clean;
  logic             r_out_flip;
  logic [0:WIDTH-1] w_head_cw_nxt;
  logic [0:WIDTH-1] w_head_clean_nxt;
  logic             w_head_flip_nxt;

  logic [3:0]       w_par;
  logic [0:WIDTH-1] w_clean;
  logic [0:WIDTH-1] w_cw;
  logic             w_flip;
  logic             w_push;
  logic             w_pop;

  // Parity equations; w_par[k] lands in codeword bit 4+k
  assign w_par[0] = in_data[3] ^ in_data[2] ^ in_data[1];
  assign w_par[1] = in_data[3] ^ in_data[2] ^ in_data[0];
  assign w_par[2] = in_data[3] ^ in_data[1] ^ in_data[0];
  assign w_par[3] = in_data[2] ^ in_data[1] ^ in_data[0];

  assign w_clean[0:3] = in_data;

  for (genvar g = 4; g < WIDTH; g++) begin : g_par
    if (LEGAL) begin : g_legal
      assign w_clean[g] = w_par[g-4];
    end else begin : g_zero
      assign w_clean[g] = 1'b0;
    end
  end

  assign w_cw   = w_clean ^ in_err;
  assign w_flip = |in_err;
  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;
  assign w_rd_nxt = r_rd_ptr + AW'(1);

  // Control FSM state and its registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) w_state_nxt = S_PARTIAL;
      end
      S_PARTIAL: begin
        if (w_push && !w_pop && (r_level == LW'(DEPTH - 1))) begin
          w_state_nxt = S_FULL;
        end else if (w_pop && !w_push && (r_level == LW'(1))) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) w_state_nxt = S_PARTIAL;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    w_in_ready_nxt  = (w_state_nxt != S_FULL);
    w_out_valid_nxt = (w_state_nxt != S_EMPTY);
  end

  // Next head: the entry behind the popped one, or the incoming word when it lands at the head
  always_comb begin
    w_head_cw_nxt    = r_out_cw;
    w_head_clean_nxt = r_out_clean;
    w_head_flip_nxt  = r_out_flip;
    if (w_pop) begin
      if (r_level > LW'(1)) begin
        w_head_cw_nxt    = r_mem_cw[w_rd_nxt];
        w_head_clean_nxt = r_mem_clean[w_rd_nxt];
        w_head_flip_nxt  = r_mem_flip[w_rd_nxt];
      end else if (w_push) begin
        w_head_cw_nxt    = w_cw;
        w_head_clean_nxt = w_clean;
        w_head_flip_nxt  = w_flip;
      end
    end else if ((r_level == LW'(0)) && w_push) begin
      w_head_cw_nxt    = w_cw;
      w_head_clean_nxt = w_clean;
      w_head_flip_nxt  = w_flip;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_word_cnt  <= '0;
      r_inj_cnt   <= '0;
      r_out_cw    <= '0;
      r_out_clean <= '0;
      r_out_flip  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_nxt;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_push) begin
        r_word_cnt <= r_word_cnt + CNT_W'(1);
        if (w_flip) r_inj_cnt <= r_inj_cnt + CNT_W'(1);
      end
      r_out_cw    <= w_head_cw_nxt;
      r_out_clean <= w_head_clean_nxt;
      r_out_flip  <= w_head_flip_nxt;
    end
  end

  // FIFO storage; contents need no reset because the level gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_cw[r_wr_ptr]    <= w_cw;
      r_mem_clean[r_wr_ptr] <= w_clean;
      r_mem_flip[r_wr_ptr]  <= w_flip;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_cw     = r_out_cw;
  assign out_clean  = r_out_clean;
  assign out_flip   = r_out_flip;
  assign word_cnt   = r_word_cnt;
  assign inj_cnt    = r_inj_cnt;
  assign fifo_level = r_level;

endmodule

// File: tb/tb_grand_encoder.sv
// Scoreboard bench for grand_encoder: (8,4) and (7,4) instances driven with random and
// directed words, checked against a generator-matrix reference model.
module tb_grand_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, out_flip8;
  logic [3:0]  in_data8 = '0;
  logic [0:7]  in_err8 = '0, out_cw8, out_clean8;
  logic [15:0] word_cnt8, inj_cnt8;
  logic [2:0]  level8;

  logic        in_valid7 = 1'b0, in_ready7, out_valid7, out_ready7 = 1'b0, out_flip7;
  logic [3:0]  in_data7 = '0;
  logic [0:6]  in_err7 = '0, out_cw7, out_clean7;
  logic [15:0] word_cnt7, inj_cnt7;
  logic [2:0]  level7;

  grand_encoder #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) u_enc8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_err(in_err8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_cw(out_cw8), .out_clean(out_clean8), .out_flip(out_flip8),
    .word_cnt(word_cnt8), .inj_cnt(inj_cnt8), .fifo_level(level8)
  );

  grand_encoder #(.WIDTH(7), .DEPTH(4), .CNT_W(16)) u_enc7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
    .in_data(in_data7), .in_err(in_err7), .out_valid(out_valid7), .out_ready(out_ready7),
    .out_cw(out_cw7), .out_clean(out_clean7), .out_flip(out_flip7),
    .word_cnt(word_cnt7), .inj_cnt(inj_cnt7), .fifo_level(level7)
  );

  typedef struct {
    logic [7:0] cw;
    logic [7:0] clean;
    logic       flip;
  } exp_t;

  exp_t q8[$];
  exp_t q7[$];
  int   total = 0;
  int   bad   = 0;
  int   n8w   = 0;
  int   n8i   = 0;
  logic live;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each parity bit is the XOR of the data bits selected by a generator row
  function automatic logic [7:0] ref_cw(input logic [3:0] d, input int w);
    logic [15:0] rows;
    logic [7:0]  cw;
    rows = 16'hEDB7;
    cw   = {d, 4'b0000};
    for (int k = 0; k < 4; k++) begin
      if (k < w - 4) cw[3-k] = ^(d & rows[15-4*k -: 4]);
    end
    return cw;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Monitor/scoreboard: records accepted words, compares every popped word and FIFO state
  initial begin : mon
    exp_t       e;
    logic [7:0] t8;
    logic       prev_stall;
    logic [7:0] prev_cw;
    prev_stall = 1'b0;
    prev_cw    = '0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        q8.delete();
        q7.delete();
        prev_stall = 1'b0;
      end else begin
        if (live) begin
          check("level8", 32'(level8), q8.size());
          check("out_valid8", 32'(out_valid8), 32'(q8.size() != 0));
          check("in_ready8", 32'(in_ready8), 32'(q8.size() < 4));
        end
        if (out_valid8 && out_ready8) begin
          if (q8.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out8: got %b expected no word", out_cw8);
          end else begin
            e = q8.pop_front();
            check("cw8", 32'(out_cw8), 32'(e.cw));
            check("clean8", 32'(out_clean8), 32'(e.clean));
            check("flip8", 32'(out_flip8), 32'(e.flip));
          end
        end
        if (out_valid8 && !out_ready8) begin
          if (prev_stall) check("stall_hold8", 32'(out_cw8), 32'(prev_cw));
          prev_stall = 1'b1;
          prev_cw    = out_cw8;
        end else begin
          prev_stall = 1'b0;
        end
        if (in_valid8 && in_ready8) begin
          e.clean = ref_cw(in_data8, 8);
          e.cw    = e.clean ^ in_err8;
          e.flip  = |in_err8;
          q8.push_back(e);
        end
        if (out_valid7 && out_ready7) begin
          if (q7.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out7: got %b expected no word", out_cw7);
          end else begin
            e = q7.pop_front();
            check("cw7", 32'(out_cw7), 32'(e.cw));
            check("clean7", 32'(out_clean7), 32'(e.clean));
            check("flip7", 32'(out_flip7), 32'(e.flip));
          end
        end
        if (in_valid7 && in_ready7) begin
          t8      = ref_cw(in_data7, 7);
          e.clean = {1'b0, t8[7:1]};
          e.cw    = e.clean ^ {1'b0, in_err7};
          e.flip  = |in_err7;
          q7.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [3:0] d, input logic [7:0] err);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid8 = 1'b1;
    in_data8  = d;
    in_err8   = err;
    do begin
      @(negedge clk);
      acc = in_ready8;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send8_timeout: got no acceptance expected acceptance within 200 cycles");
    end else begin
      n8w++;
      if (|err) n8i++;
    end
    in_valid8 = 1'b0;
    in_data8  = 4'($urandom);
    in_err8   = 8'($urandom);
  endtask

  task automatic send7(input logic [3:0] d, input logic [6:0] err);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    in_valid7 = 1'b1;
    in_data7  = d;
    in_err7   = err;
    do begin
      @(negedge clk);
      acc = in_ready7;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send7_timeout: got no acceptance expected acceptance within 200 cycles");
    end
    in_valid7 = 1'b0;
    in_data7  = 4'($urandom);
    in_err7   = 7'($urandom);
  endtask

  task automatic drain8();
    int n;
    n = 0;
    out_ready8 = 1'b1;
    while (level8 != 3'd0 && n < 100) begin
      tick();
      n++;
    end
    check("drain8", 32'(level8), 32'd0);
  endtask

  initial begin : main
    bit         done;
    int         n;
    logic [7:0] e8;
    #2;
    check("rst_in_ready8", 32'(in_ready8), 0);
    check("rst_out_valid8", 32'(out_valid8), 0);
    check("rst_out_cw8", 32'(out_cw8), 0);
    check("rst_out_clean8", 32'(out_clean8), 0);
    check("rst_out_flip8", 32'(out_flip8), 0);
    check("rst_word_cnt8", 32'(word_cnt8), 0);
    check("rst_inj_cnt8", 32'(inj_cnt8), 0);
    check("rst_level8", 32'(level8), 0);
    check("rst_in_ready7", 32'(in_ready7), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", 32'(in_ready8), 1);

    // First word: one-cycle latency and known codeword
    out_ready8 = 1'b1;
    send8(4'b0011, 8'h00);
    check("lat_out_valid", 32'(out_valid8), 1);
    check("lat_out_cw", 32'(out_cw8), 32'(8'b00111100));
    check("lat_out_clean", 32'(out_clean8), 32'(8'b00111100));
    check("lat_word_cnt", 32'(word_cnt8), 1);
    check("lat_inj_cnt", 32'(inj_cnt8), 0);

    for (int d = 0; d < 16; d++) send8(4'(d), 8'h00);
    tick();
    check("table_word_cnt", 32'(word_cnt8), 32'(n8w));

    // (7,4) instance with a single flipped parity bit
    out_ready7 = 1'b1;
    send7(4'b1101, 7'b0000001);
    check("w7_clean", 32'(out_clean7), 32'(7'b1101010));
    check("w7_cw", 32'(out_cw7), 32'(7'b1101011));
    check("w7_flip", 32'(out_flip7), 1);
    check("w7_inj_cnt", 32'(inj_cnt7), 1);
    for (int i = 0; i < 10; i++) send7(4'($urandom), ($urandom % 2) ? 7'($urandom) : 7'h00);

    // Random traffic with random downstream backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          e8 = ($urandom % 2) ? 8'($urandom) : 8'h00;
          send8(4'($urandom), e8);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready8 = 1'($urandom);
          tick();
        end
      end
    join
    drain8();
    check("rand_word_cnt", 32'(word_cnt8), 32'(n8w));
    check("rand_inj_cnt", 32'(inj_cnt8), 32'(n8i));

    // Full FIFO: fifth word held off until a single pop frees an entry
    out_ready8 = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send8(4'($urandom), ($urandom % 2) ? 8'($urandom) : 8'h00);
      end
      begin
        n = 0;
        while (level8 != 3'd4 && n < 50) begin
          tick();
          n++;
        end
        repeat (3) tick();
        check("full_in_ready", 32'(in_ready8), 0);
        check("full_level", 32'(level8), 4);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check("pop_frees_in_ready", 32'(in_ready8), 1);
        tick();
        check("fifth_accepted_level", 32'(level8), 4);
        out_ready8 = 1'b1;
      end
    join
    drain8();

    // Steady push/pop at level 2 across pointer wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n8w = 0;
    n8i = 0;
    tick();
    out_ready8 = 1'b0;
    send8(4'($urandom), 8'h00);
    send8(4'($urandom), 8'h00);
    out_ready8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send8(4'($urandom), ($urandom % 2) ? 8'($urandom) : 8'h00);
      check("steady_level", 32'(level8), 2);
    end
    check("steady_word_cnt", 32'(word_cnt8), 12);
    drain8();

    // Asynchronous reset mid-cycle with three words queued
    out_ready8 = 1'b0;
    for (int i = 0; i < 3; i++) send8(4'($urandom), 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid8), 0);
    check("arst_word_cnt", 32'(word_cnt8), 0);
    check("arst_inj_cnt", 32'(inj_cnt8), 0);
    check("arst_level", 32'(level8), 0);
    check("arst_in_ready", 32'(in_ready8), 0);
    tick();
    rst_n = 1'b1;
    tick();
    out_ready8 = 1'b1;
    repeat (5) tick();
    check("no_stale_valid", 32'(out_valid8), 0);
    check("no_stale_cnt", 32'(word_cnt8), 0);
    send8(4'b1010, 8'h00);
    check("post_rst_cw", 32'(out_cw8), 32'(8'b10100101));
    drain8();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
